// File: rtl/cmd_uart_tx.sv
// cmd_uart_tx
//    8N1 serial transmitter for the car command byte. A frame is launched
//    whenever the command differs from the last byte sent, when a change was
//    seen while a frame was in flight, or when the keep-alive timer
//    saturates after REFRESH_CYC idle cycles with the command unchanged.
//
// Ports
//    clk         system clock, all logic on the rising edge
//    rst         synchronous active-high reset
//    enable      1 = launches allowed; 0 = finish the current frame, then idle
//    cmd_in      command byte, sampled every cycle
//    txd         serial line, idle high
//    busy        high from the first start-bit cycle to the last stop-bit cycle
//    frame_done  one-cycle pulse in the cycle after the stop bit ends
//    sent_cmd    byte most recently latched for transmission
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line high; launch when enabled and something is owed
// START  | start bit (low) for DIV cycles
// DATA   | 8 data bits, LSB first, DIV cycles each
// STOP   | stop bit (high) for DIV cycles, then back to IDLE + frame_done

module cmd_uart_tx #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int BAUD        = 9600,
   parameter int REFRESH_CYC = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] cmd_in,
   output logic       txd,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] sent_cmd
);

   localparam int DIV    = CLK_FREQ / BAUD;
   localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int REF_W  = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
   localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t              state_q,       state_d;
   logic [BAUD_W-1:0]   baud_cnt_q,    baud_cnt_d;
   logic [2:0]          bit_idx_q,     bit_idx_d;
   logic [7:0]          shreg_q,       shreg_d;
   logic [7:0]          last_sent_q,   last_sent_d;
   logic                pending_q,     pending_d;
   logic [REF_W-1:0]    refresh_cnt_q, refresh_cnt_d;
   logic                txd_q,         txd_d;
   logic                busy_q,        busy_d;
   logic                frame_done_q,  frame_done_d;

   logic                bit_end;

   always_comb begin
      state_d       = state_q;
      baud_cnt_d    = baud_cnt_q;
      bit_idx_d     = bit_idx_q;
      shreg_d       = shreg_q;
      last_sent_d   = last_sent_q;
      pending_d     = pending_q;
      refresh_cnt_d = refresh_cnt_q;
      frame_done_d  = 1'b0;
      bit_end       = (baud_cnt_q == BAUD_LAST);

      case (state_q)
         ST_IDLE: begin
            baud_cnt_d = '0;
            bit_idx_d  = 3'd0;
            // Timer and pending flag freeze while transmission is disabled.
            if (enable) begin
               if (refresh_cnt_q != REF_LAST) begin
                  refresh_cnt_d = refresh_cnt_q + REF_W'(1);
               end
               if ((cmd_in != last_sent_q) || pending_q || (refresh_cnt_q == REF_LAST)) begin
                  shreg_d       = cmd_in;
                  last_sent_d   = cmd_in;
                  pending_d     = 1'b0;
                  refresh_cnt_d = '0;
                  state_d       = ST_START;
               end
            end
         end
         default: begin
            // Frame in flight is never altered; a change only schedules a
            // follow-up frame carrying whatever cmd_in is at that time.
            if (cmd_in != last_sent_q) begin
               pending_d = 1'b1;
            end
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
            if (bit_end) begin
               case (state_q)
                  ST_START: state_d = ST_DATA;
                  ST_DATA: begin
                     if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                     end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                     end
                  end
                  default: begin
                     state_d      = ST_IDLE;
                     frame_done_d = 1'b1;
                  end
               endcase
            end
         end
      endcase

      // Line level is registered from the next state so txd is glitch-free.
      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shreg_d[0];
         default:  txd_d = 1'b1;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         baud_cnt_q    <= '0;
         bit_idx_q     <= 3'd0;
         shreg_q       <= 8'h00;
         last_sent_q   <= 8'h00;
         pending_q     <= 1'b0;
         refresh_cnt_q <= '0;
         txd_q         <= 1'b1;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         baud_cnt_q    <= baud_cnt_d;
         bit_idx_q     <= bit_idx_d;
         shreg_q       <= shreg_d;
         last_sent_q   <= last_sent_d;
         pending_q     <= pending_d;
         refresh_cnt_q <= refresh_cnt_d;
         txd_q         <= txd_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
      end
   end

   // last_sent and sent_cmd are latched together at every launch, so one
   // register serves both.
   assign txd        = txd_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign sent_cmd   = last_sent_q;

endmodule

// File: tb/tb_cmd_uart_tx.sv
`timescale 1ns/1ps

module tb_cmd_uart_tx;

   localparam int DIV     = 16;
   localparam int FRAME   = 10 * DIV;
   localparam int REFRESH = 400;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic [7:0] cmd_in = 8'hA1;
   logic       txd;
   logic       busy;
   logic       frame_done;
   logic [7:0] sent_cmd;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   cmd_uart_tx #(
      .CLK_FREQ   (160),
      .BAUD       (10),
      .REFRESH_CYC(REFRESH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .cmd_in    (cmd_in),
      .txd       (txd),
      .busy      (busy),
      .frame_done(frame_done),
      .sent_cmd  (sent_cmd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // UART receiver model sampling mid-bit, plus a per-cycle command history.
   typedef struct {
      int         start;
      logic [7:0] data;
      logic [7:0] sent;
      logic [7:0] cmd_launch;
      bit         ok;
   } rx_t;

   rx_t        rx_q[$];
   rx_t        cur;
   bit         rx_active = 0;
   bit         rec_hist = 0;
   logic [7:0] prev_cmd = 8'h00;
   logic [7:0] cmd_hist[int];
   int         off;
   int         idx;

   always @(negedge clk) begin
      if (rec_hist) cmd_hist[cyc] = cmd_in;
      if (frame_done === 1'b1) begin
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fd_busy_excl: busy=%0b with frame_done at cycle %0d, required 0", busy, cyc);
         end
      end
      if (rst) begin
         rx_active = 0;
      end else if (!rx_active) begin
         if (txd === 1'b0) begin
            rx_active      = 1;
            cur.start      = cyc;
            cur.sent       = sent_cmd;
            cur.cmd_launch = prev_cmd;
            cur.data       = 8'h00;
            cur.ok         = 1;
         end
      end else begin
         off = cyc - cur.start;
         if (off % DIV == DIV / 2) begin
            idx = off / DIV;
            if (idx == 0) begin
               if (txd !== 1'b0) cur.ok = 0;
            end else if (idx <= 8) begin
               cur.data[idx-1] = txd;
            end else begin
               if (txd !== 1'b1) cur.ok = 0;
               rx_q.push_back(cur);
               rx_active = 0;
            end
         end
      end
      prev_cmd = cmd_in;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   function automatic logic fbit(input logic [7:0] b, input int k);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      return f[k];
   endfunction

   int rel_cyc;

   task automatic test_reset();
      rst = 1'b1;
      enable = 1'b1;
      cmd_in = 8'hA1;
      ticks(3);
      checks += 4;
      if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b, required 1", txd); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
      if (sent_cmd !== 8'h00) begin errors++; $display("FAIL reset_sent_cmd: got %h, required 00", sent_cmd); end
      rst = 1'b0;
      rel_cyc = cyc;
   endtask

   task automatic test_first_frame();
      int bad_txd = 0, bad_busy = 0, bad_fd = 0;
      logic exp_txd;
      for (int i = 0; i <= FRAME; i++) begin
         tick();
         exp_txd = (i < FRAME) ? fbit(8'hA1, i / DIV) : 1'b1;
         if (txd !== exp_txd) bad_txd++;
         if (busy !== (i < FRAME)) bad_busy++;
         if (frame_done !== (i == FRAME)) bad_fd++;
      end
      checks += 5;
      if (bad_txd != 0) begin errors++; $display("FAIL first_txd: %0d cycles wrong, required 0", bad_txd); end
      if (bad_busy != 0) begin errors++; $display("FAIL first_busy: %0d cycles wrong, required 0", bad_busy); end
      if (bad_fd != 0) begin errors++; $display("FAIL first_frame_done: %0d cycles wrong, required 0", bad_fd); end
      if (sent_cmd !== 8'hA1) begin errors++; $display("FAIL first_sent_cmd: got %h, required a1", sent_cmd); end
      if (rx_q.size() != 1 || rx_q[0].data !== 8'hA1 || !rx_q[0].ok || rx_q[0].start != rel_cyc + 1) begin
         errors++;
         $display("FAIL first_rx: got %0d frames (first data %h start %0d), required 1 frame a1 at %0d",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0].data : 8'h00,
                  (rx_q.size() > 0) ? rx_q[0].start : -1, rel_cyc + 1);
      end
      rx_q.delete();
   endtask

   // Returns cycles until txd goes low, or -1 if it stays high for max cycles.
   task automatic wait_start(input int max, output int n);
      n = -1;
      for (int k = 1; k <= max; k++) begin
         tick();
         if (txd === 1'b0) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_refresh();
      int n;
      wait_start(450, n);
      checks += 3;
      if (n != REFRESH) begin errors++; $display("FAIL refresh_gap: got %0d cycles, required %0d", n, REFRESH); end
      ticks(FRAME);
      if (frame_done !== 1'b1) begin errors++; $display("FAIL refresh_frame_done: got %b, required 1", frame_done); end
      if (rx_q.size() != 1 || rx_q[0].data !== 8'hA1) begin
         errors++;
         $display("FAIL refresh_rx: got %0d frames, required 1 frame a1", rx_q.size());
      end
      rx_q.delete();
   endtask

   task automatic test_coalesce();
      int n, s, extra;
      wait_start(450, n);
      s = cyc;
      ticks(30);
      cmd_in = 8'hA2;
      ticks(60);
      cmd_in = 8'hA4;
      ticks(70);
      checks += 5;
      if (frame_done !== 1'b1) begin errors++; $display("FAIL coal_fd1: got %b, required 1", frame_done); end
      tick();
      if (txd !== 1'b0) begin errors++; $display("FAIL coal_restart: txd got %b, required 0", txd); end
      ticks(FRAME);
      if (frame_done !== 1'b1) begin errors++; $display("FAIL coal_fd2: got %b, required 1", frame_done); end
      extra = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (txd !== 1'b1) extra++;
      end
      if (extra != 0) begin errors++; $display("FAIL coal_quiet: %0d low cycles, required 0", extra); end
      if (rx_q.size() != 2 || rx_q[0].data !== 8'hA1 || rx_q[1].data !== 8'hA4 ||
          rx_q[0].start != s || rx_q[1].start != s + FRAME + 1) begin
         errors++;
         $display("FAIL coal_rx: got %0d frames, required a1 at %0d and a4 at %0d", rx_q.size(), s, s + FRAME + 1);
      end
      rx_q.delete();
   endtask

   task automatic test_enable_drop();
      int s, e, extra;
      cmd_in = 8'hB3;
      tick();
      s = cyc;
      checks += 6;
      if (txd !== 1'b0) begin errors++; $display("FAIL en_start: txd got %b, required 0", txd); end
      ticks(64);
      enable = 1'b0;
      ticks(6);
      cmd_in = 8'h88;
      ticks(90);
      if (frame_done !== 1'b1) begin errors++; $display("FAIL en_fd: got %b, required 1", frame_done); end
      extra = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (txd !== 1'b1 || busy !== 1'b0) extra++;
      end
      if (extra != 0) begin errors++; $display("FAIL en_idle: %0d active cycles, required 0", extra); end
      enable = 1'b1;
      e = cyc;
      tick();
      if (txd !== 1'b0) begin errors++; $display("FAIL en_resume: txd got %b, required 0", txd); end
      ticks(FRAME);
      if (frame_done !== 1'b1) begin errors++; $display("FAIL en_fd2: got %b, required 1", frame_done); end
      if (rx_q.size() != 2 || rx_q[0].data !== 8'hB3 || rx_q[1].data !== 8'h88 ||
          rx_q[0].start != s || rx_q[1].start != e + 1) begin
         errors++;
         $display("FAIL en_rx: got %0d frames, required b3 at %0d and 88 at %0d", rx_q.size(), s, e + 1);
      end
      rx_q.delete();
   endtask

   task automatic test_reset_mid();
      int s;
      cmd_in = 8'hC5;
      tick();
      s = cyc;
      ticks(100);
      rst = 1'b1;
      tick();
      checks += 8;
      if (txd !== 1'b1) begin errors++; $display("FAIL rmid_txd: got %b, required 1", txd); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, required 0", busy); end
      if (sent_cmd !== 8'h00) begin errors++; $display("FAIL rmid_sent: got %h, required 00", sent_cmd); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL rmid_fd: got %b, required 0", frame_done); end
      rst = 1'b0;
      tick();
      if (txd !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rmid_restart: txd=%b busy=%b, required 0/1", txd, busy);
      end
      ticks(FRAME);
      if (frame_done !== 1'b1) begin errors++; $display("FAIL rmid_fd2: got %b, required 1", frame_done); end
      if (sent_cmd !== 8'hC5) begin errors++; $display("FAIL rmid_sent2: got %h, required c5", sent_cmd); end
      if (rx_q.size() != 1 || rx_q[0].data !== 8'hC5 || !rx_q[0].ok || rx_q[0].start != s + 102) begin
         errors++;
         $display("FAIL rmid_rx: got %0d frames, required 1 frame c5 at %0d", rx_q.size(), s + 102);
      end
      rx_q.delete();
   endtask

   task automatic test_random();
      int         budget;
      int         fd, t, exp_launch;
      bit         changed;
      logic [7:0] exp_prev, exp_cur;
      rx_t        p, c;
      rx_q.delete();
      rec_hist = 1;
      budget = 0;
      while (rx_q.size() < 50 && budget < 40000) begin
         if ($urandom_range(0, 149) == 0) cmd_in = 8'h80 | 8'($urandom_range(0, 63));
         tick();
         budget++;
      end
      rec_hist = 0;
      checks++;
      if (rx_q.size() < 50) begin
         errors++;
         $display("FAIL rand_count: got %0d frames, required 50", rx_q.size());
      end
      for (int i = 0; i < rx_q.size(); i++) begin
         c = rx_q[i];
         exp_cur = cmd_hist.exists(c.start - 1) ? cmd_hist[c.start - 1] : c.cmd_launch;
         checks += 3;
         if (c.data !== exp_cur) begin errors++; $display("FAIL rand_data[%0d]: got %h, required %h", i, c.data, exp_cur); end
         if (!c.ok) begin errors++; $display("FAIL rand_framing[%0d]: got bad stop/start, required clean frame", i); end
         if (c.sent !== exp_cur) begin errors++; $display("FAIL rand_sent[%0d]: got %h, required %h", i, c.sent, exp_cur); end
         if (i > 0) begin
            p = rx_q[i-1];
            exp_prev = cmd_hist.exists(p.start - 1) ? cmd_hist[p.start - 1] : p.cmd_launch;
            fd = p.start + FRAME;
            changed = 0;
            for (int k = p.start; k < fd; k++) begin
               if (cmd_hist.exists(k) && cmd_hist[k] != exp_prev) changed = 1;
            end
            if (changed) begin
               exp_launch = fd;
            end else begin
               t = fd;
               while ((t - fd) < REFRESH - 1 && cmd_hist.exists(t) && cmd_hist[t] == exp_prev) t++;
               exp_launch = t;
            end
            checks++;
            if (c.start - 1 != exp_launch) begin
               errors++;
               $display("FAIL rand_launch[%0d]: launched at %0d, required %0d", i, c.start - 1, exp_launch);
            end
         end
      end
      rx_q.delete();
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_refresh();
      test_coalesce();
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
